// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states, sweep
// geometry for the default 3-input lab circuit, and its expected truth table.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int N_IN_DEFAULT = 3;
  localparam int NVEC         = 2 ** N_IN_DEFAULT;
  localparam int CNT_W        = N_IN_DEFAULT + 1;

  // Truth table of out = ~(~A & B & C); bit i is the output for {A,B,C} == i.
  localparam logic [NVEC-1:0] EXPECTED_DEFAULT = 8'hF7;

  // Wide enough for the largest legal settle time (15).
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter: after a load, expire asserts on the SETTLE_CYCLES-th
// enabled cycle, which is the last cycle a vector is held before sampling.
module sweep_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a small combinational circuit, holds each for a
// programmable settle time, captures the output and grades it against a table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                    N_IN          = N_IN_DEFAULT,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0]    EXPECTED      = EXPECTED_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [N_IN-1:0]     dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  table_out,
  output logic [N_IN:0]       mismatch_cnt,
  output logic [N_IN-1:0]     mismatch_idx
);

  localparam int              NUM_VEC  = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NUM_VEC - 1);

  sweep_state_e    state;
  logic [N_IN-1:0] idx;
  logic            tmr_load;
  logic            tmr_en;
  logic            tmr_expire;

  // The timer restarts on every entry into SETTLE: at sweep acceptance and
  // after each non-final sample.
  assign tmr_load = !abort &&
                    (((state == IDLE) && start) ||
                     ((state == SAMPLE) && (idx != LAST_IDX)));
  assign tmr_en   = (state == SETTLE);

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      mismatch_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_in <= '0;
          busy   <= 1'b0;
          if (start && !abort) begin
            state        <= SETTLE;
            idx          <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
          end else if (tmr_expire) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // An aborted sample is discarded; partial results stay visible.
            state  <= IDLE;
            busy   <= 1'b0;
            dut_in <= '0;
          end else begin
            table_out[idx] <= dut_out;
            if (dut_out != EXPECTED[idx]) begin
              mismatch_cnt <= mismatch_cnt + 1'b1;
              if (mismatch_cnt == '0) begin
                mismatch_idx <= idx;
              end
            end
            if (idx == LAST_IDX) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              dut_in <= '0;
            end else begin
              state  <= SETTLE;
              idx    <= idx + 1'b1;
              dut_in <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          dut_in <= '0;
          // mismatch_cnt already holds the final vector's contribution here.
          if (!abort) begin
            pass <= (mismatch_cnt == '0);
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          dut_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 2 and settle 1) graded every cycle
// against a cycle-position model, plus directed literal checks.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic stuck = 1'b0, stuck1 = 1'b0;
  logic [NVEC-1:0] flip = '0, flip1 = '0;

  logic [N_IN_DEFAULT-1:0] dut_in, dut_in1, mismatch_idx, mismatch_idx1;
  logic dut_out, dut_out1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [NVEC-1:0] table_out, table_out1;
  logic [CNT_W-1:0] mismatch_cnt, mismatch_cnt1;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lab circuit out = ~(~A & B & C), with optional injected faults.
  function automatic logic lab(input logic [N_IN_DEFAULT-1:0] v);
    return ~(~v[2] & v[1] & v[0]);
  endfunction

  assign dut_out  = stuck  | (lab(dut_in)  ^ flip[dut_in]);
  assign dut_out1 = stuck1 | (lab(dut_in1) ^ flip1[dut_in1]);

  truth_table_sweeper #(.N_IN(N_IN_DEFAULT), .SETTLE_CYCLES(S0), .EXPECTED(EXPECTED_DEFAULT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .table_out(table_out), .mismatch_cnt(mismatch_cnt), .mismatch_idx(mismatch_idx));

  truth_table_sweeper #(.N_IN(N_IN_DEFAULT), .SETTLE_CYCLES(S1), .EXPECTED(EXPECTED_DEFAULT)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table_out1), .mismatch_cnt(mismatch_cnt1), .mismatch_idx(mismatch_idx1));

  // Model: t = 0 idle, t = 1..len sweeping (cycle t after the accepting edge),
  // t = len+1 the done cycle. Vector v is sampled at the end of t = (v+1)(s+1).
  typedef struct {
    int              t;
    logic [NVEC-1:0] tbl;
    int              cnt;
    int              midx;
    logic            pass;
  } model_t;

  function automatic model_t m_reset();
    model_t r;
    r.t = 0; r.tbl = '0; r.cnt = 0; r.midx = 0; r.pass = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input int s, input logic st,
                                        input logic ab, input logic dout);
    model_t n;
    int len;
    int v;
    n = m;
    len = NVEC * (s + 1);
    if (m.t == 0) begin
      if (st && !ab) begin
        n.t = 1; n.tbl = '0; n.cnt = 0; n.midx = 0; n.pass = 1'b0;
      end
    end else if (ab) begin
      n.t = 0;
    end else if (m.t == len + 1) begin
      n.pass = (m.cnt == 0);
      n.t = 0;
    end else begin
      if (m.t % (s + 1) == 0) begin
        v = m.t / (s + 1) - 1;
        n.tbl[v] = dout;
        if (dout != EXPECTED_DEFAULT[v]) begin
          if (m.cnt == 0) n.midx = v;
          n.cnt = m.cnt + 1;
        end
      end
      n.t = m.t + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag, input model_t m, input int s,
                             input logic [31:0] a_din, input logic [31:0] a_busy,
                             input logic [31:0] a_done, input logic [31:0] a_pass,
                             input logic [31:0] a_tbl, input logic [31:0] a_cnt,
                             input logic [31:0] a_idx);
    int len;
    logic sweeping;
    len = NVEC * (s + 1);
    sweeping = (m.t >= 1) && (m.t <= len);
    check({tag, " dut_in"}, a_din, sweeping ? 32'((m.t - 1) / (s + 1)) : 32'd0);
    check({tag, " busy"}, a_busy, {31'd0, sweeping});
    check({tag, " done"}, a_done, {31'd0, (m.t == len + 1)});
    check({tag, " pass"}, a_pass, {31'd0, m.pass});
    check({tag, " table_out"}, a_tbl, 32'(m.tbl));
    check({tag, " mismatch_cnt"}, a_cnt, 32'(m.cnt));
    check({tag, " mismatch_idx"}, a_idx, 32'(m.midx));
  endtask

  model_t m0, m1;
  logic s_start, s_abort, s_out, s_start1, s_abort1, s_out1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= m_reset();
      m1 <= m_reset();
    end else begin
      m0 <= model_step(m0, S0, s_start, s_abort, s_out);
      m1 <= model_step(m1, S1, s_start1, s_abort1, s_out1);
    end
  end

  // Inputs change just after posedge, so mid-cycle snapshots are what the DUT samples.
  always @(negedge clk) begin
    s_start <= start;  s_abort <= abort;  s_out <= dut_out;
    s_start1 <= start1; s_abort1 <= abort1; s_out1 <= dut_out1;
    compare_all("s2", m0, S0, 32'(dut_in), 32'(busy), 32'(done), 32'(pass),
                32'(table_out), 32'(mismatch_cnt), 32'(mismatch_idx));
    compare_all("s1", m1, S1, 32'(dut_in1), 32'(busy1), 32'(done1), 32'(pass1),
                32'(table_out1), 32'(mismatch_cnt1), 32'(mismatch_idx1));
  end

  task automatic set_start(input int which, input logic v);
    if (which == 0) start = v; else start1 = v;
  endtask

  function automatic logic get_done(input int which);
    return (which == 0) ? done : done1;
  endfunction

  // Pulses start, then watches 40 cycles; lat is done's edge offset from the start edge.
  task automatic run_and_wait(input int which, input int repulse_at, output int lat, output int pulses);
    int s_cyc;
    lat = -1;
    pulses = 0;
    @(posedge clk); #1;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    s_cyc = cyc;
    set_start(which, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (repulse_at >= 0 && (cyc - s_cyc) == repulse_at - 1) set_start(which, 1'b1);
      @(posedge clk); #1;
      set_start(which, 1'b0);
      if (get_done(which)) begin
        pulses++;
        if (lat < 0) lat = cyc - s_cyc;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, pulses, s_cyc;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset table_out", 32'(table_out), 32'd0);
    #1 rst_n = 1'b1;

    // 1: correct circuit
    run_and_wait(0, -1, lat, pulses);
    check("t1 done latency", 32'(lat), 32'd24);
    check("t1 done pulses", 32'(pulses), 32'd1);
    check("t1 table_out", 32'(table_out), 32'hF7);
    check("t1 mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("t1 pass", 32'(pass), 32'd1);

    // 2: output stuck at 1
    stuck = 1'b1;
    run_and_wait(0, -1, lat, pulses);
    check("t2 done latency", 32'(lat), 32'd24);
    check("t2 table_out", 32'(table_out), 32'hFF);
    check("t2 mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    check("t2 mismatch_idx", 32'(mismatch_idx), 32'd3);
    check("t2 pass", 32'(pass), 32'd0);
    stuck = 1'b0;

    // 3: abort sampled at edge 10
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_cyc = cyc;
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t3 abort edge", 32'(cyc - s_cyc), 32'd10);
    check("t3 busy", 32'(busy), 32'd0);
    check("t3 dut_in", 32'(dut_in), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("t3 done pulses", 32'(pulses), 32'd0);
    check("t3 pass", 32'(pass), 32'd0);
    check("t3 table_out", 32'(table_out), 32'h07);

    // 4: start re-pulsed at edge 5, then start+abort in IDLE
    run_and_wait(0, 5, lat, pulses);
    check("t4 done latency", 32'(lat), 32'd24);
    check("t4 done pulses", 32'(pulses), 32'd1);
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    check("t4 start+abort busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t4 start+abort busy later", 32'(busy), 32'd0);

    // 5: asynchronous reset mid-cycle after edge 13
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("t5 busy before reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5 rst dut_in", 32'(dut_in), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst done", 32'(done), 32'd0);
    check("t5 rst pass", 32'(pass), 32'd0);
    check("t5 rst table_out", 32'(table_out), 32'd0);
    check("t5 rst mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    check("t5 rst mismatch_idx", 32'(mismatch_idx), 32'd0);
    #3 rst_n = 1'b1;
    run_and_wait(0, -1, lat, pulses);
    check("t5 done latency", 32'(lat), 32'd24);
    check("t5 table_out", 32'(table_out), 32'hF7);
    check("t5 pass", 32'(pass), 32'd1);

    // 6: settle of one cycle
    run_and_wait(1, -1, lat, pulses);
    check("t6 done latency", 32'(lat), 32'd16);
    check("t6 table_out", 32'(table_out1), 32'hF7);
    check("t6 mismatch_cnt", 32'(mismatch_cnt1), 32'd0);
    check("t6 pass", 32'(pass1), 32'd1);

    // Randomised traffic, graded by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 7) == 0);
      start1 = ($urandom_range(0, 7) == 0);
      abort  = ($urandom_range(0, 59) == 0);
      abort1 = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) flip  = NVEC'($urandom) & NVEC'($urandom);
      if ($urandom_range(0, 39) == 0) flip1 = NVEC'($urandom) & NVEC'($urandom);
      if ($urandom_range(0, 99) == 0) stuck  = ~stuck;
      if ($urandom_range(0, 99) == 0) stuck1 = ~stuck1;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1 begin start = 1'b0; start1 = 1'b0; abort = 1'b0; abort1 = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
